// File: rtl/mem_bus_master.sv
// mem_bus_master: single-outstanding load/store front end for the shared
// memory bus. Captures one request, checks alignment, runs a timed write or
// read strobe, then returns a one-cycle response with extended load data.
module mem_bus_master #(
    parameter int READ_LATENCY = 1,
    parameter int WRITE_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_address,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    inout  wire  [63:0] bus_data,
    output logic [31:0] bus_address,
    output logic        bus_mem_write,
    output logic        bus_mem_read,
    output logic [1:0]  bus_size
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter value on the final cycle of each strobe phase.
    localparam logic [3:0] RD_LAST = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WR_LAST = 4'(WRITE_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic        r_ready;
    logic [3:0]  r_cnt;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [63:0] r_wdata;
    logic [63:0] r_rdata;
    logic        r_fault;
    logic        w_accept;
    logic        w_misaligned;
    logic        w_on_bus;

    // Natural alignment: the address must be a multiple of the access size.
    function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        logic bad;
        bad = 1'b0;
        case (size)
            2'b01:   bad = addr[0];
            2'b10:   bad = (addr[1:0] != 2'b00);
            2'b11:   bad = (addr[2:0] != 3'b000);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    // Right-justified slave data is trimmed to the access width, then sign- or zero-extended.
    function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                                input logic sgn);
        logic [63:0] res;
        case (size)
            2'b00:   res = {{56{sgn & raw[7]}},  raw[7:0]};
            2'b01:   res = {{48{sgn & raw[15]}}, raw[15:0]};
            2'b10:   res = {{32{sgn & raw[31]}}, raw[31:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    // ready is registered so it stays low while reset is held and rises on the first edge after.
    assign w_accept     = req_valid && r_ready;
    assign w_misaligned = is_misaligned(req_address, req_size);
    assign w_on_bus     = (r_state == S_WRITE) || (r_state == S_READ);

    // Next-state selection; misaligned requests skip the bus entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned)   w_next = S_RESP;
                    else if (req_write) w_next = S_WRITE;
                    else                w_next = S_READ;
                end
            end
            S_WRITE: if (r_cnt == WR_LAST) w_next = S_RESP;
            S_READ:  if (r_cnt == RD_LAST) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control state: FSM, ready flag and phase counter (restarts on every state change).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b0;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == S_IDLE);
            r_cnt   <= (w_next != r_state) ? 4'd0 : r_cnt + 4'd1;
        end
    end

    // Request capture at acceptance and load-data sampling on the last read cycle.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_addr   <= req_address;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_wdata  <= req_wdata;
            r_fault  <= w_misaligned;
            r_rdata  <= 64'd0;
        end else if ((r_state == S_READ) && (r_cnt == RD_LAST)) begin
            r_rdata  <= extend_load(bus_data, r_size, r_signed);
        end
    end

    // Outputs decode from state so they drop immediately when reset asserts.
    assign req_ready     = r_ready;
    assign resp_valid    = (r_state == S_RESP);
    assign resp_fault    = resp_valid & r_fault;
    assign resp_rdata    = resp_valid ? r_rdata : 64'd0;
    assign bus_address   = w_on_bus ? r_addr : 32'd0;
    assign bus_size      = w_on_bus ? r_size : 2'd0;
    assign bus_mem_write = (r_state == S_WRITE);
    assign bus_mem_read  = (r_state == S_READ);
    assign bus_data      = (r_state == S_WRITE) ? r_wdata : 64'bz;

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- Load/store front end that sits directly upstream of the RAM address-decode/RAM block on the shared memory bus.
- Accepts one memory request at a time from the execute/memory pipeline stage over a valid/ready handshake.
- Sequences the bus signals: address, size, mem_read, mem_write, and the tristate 64-bit data.
- Returns one response per request: aligned, zero- or sign-extended load data, or an alignment fault.

Parameters:
- READ_LATENCY, 1, number of cycles mem_read is held before the read data is sampled (range 1-15).
- WRITE_CYCLES, 1, number of cycles mem_write and the data drive are held (range 1-15).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_address  in  32  byte address.
- req_size  in  2  00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = 64-bit.
- req_signed  in  1  sign-extend load result; ignored for stores.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  single-cycle response pulse.
- resp_rdata  out  64  extended load data; 0 for stores and faults.
- resp_fault  out  1  misaligned request; qualified by resp_valid.
- bus_data  inout  64  shared memory data bus.
- bus_address  out  32  bus address.
- bus_mem_write  out  1  bus write strobe.
- bus_mem_read  out  1  bus read strobe.
- bus_size  out  2  bus access size, same encoding as req_size.

Behaviour:
- Reset (asynchronous, immediate on reset_n low):
  - state = IDLE.
  - req_ready = 0 while reset_n is low, 1 from the first edge after release.
  - resp_valid = 0, resp_rdata = 0, resp_fault = 0.
  - bus_address = 0, bus_size = 0, bus_mem_read = 0, bus_mem_write = 0.
  - bus_data = high-Z.
- Reset mid-operation aborts the transfer. No response is ever issued for the aborted request.
- States: IDLE, WRITE, READ, RESP.
- Request capture: a request is accepted on an edge where req_valid && req_ready. req_ready = 1 only in IDLE. Address, size, signed flag and wdata are registered at acceptance.
- Alignment check at acceptance. The access is misaligned if any of these holds:
  - size 01 and address[0] != 0;
  - size 10 and address[1:0] != 0;
  - size 11 and address[2:0] != 0.
- IDLE transitions:
  - Misaligned: go to RESP with fault = 1. No bus activity occurs.
  - Aligned store: go to WRITE.
  - Aligned load: go to READ.
- WRITE:
  - bus_address and bus_size are driven from the captured values; bus_mem_write = 1.
  - bus_data is driven with the captured wdata.
  - Held for exactly WRITE_CYCLES cycles, counted by a 4-bit counter, then go to RESP.
  - bus_data returns to high-Z in the first RESP cycle.
- READ:
  - bus_address and bus_size are driven; bus_mem_read = 1; bus_data stays high-Z throughout.
  - Held READ_LATENCY cycles. bus_data is sampled on the edge ending the last READ cycle, then go to RESP.
  - The slave returns data right-justified.
- Load extension:
  - size 00 uses bits [7:0], size 01 uses [15:0], size 10 uses [31:0], size 11 uses all 64 bits.
  - When req_signed = 1, the top bit of the used field is replicated; otherwise the upper bits are zero-filled.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_rdata and resp_fault valid in that cycle.
  - All bus strobes are 0 and bus_address = 0.
  - Next state is IDLE.
  - There is no response backpressure; the consumer must take the pulse.
- Request-to-response latency (accept edge to resp_valid high):
  - fault: 1 cycle;
  - store: WRITE_CYCLES + 1;
  - load: READ_LATENCY + 1.
- Back-to-back requests: the minimum request spacing is fault 2, store WRITE_CYCLES + 2, load READ_LATENCY + 2 cycles. req_valid held during a busy period is accepted on the first IDLE cycle.
- Exclusivity:
  - bus_mem_read and bus_mem_write are never high in the same cycle.
  - bus_data is driven only in WRITE.
- Request inputs that change while not in IDLE are ignored.

Test Plan:
- Store then load, defaults: store address 0x10, size 11, wdata 0x0123456789ABCDEF, then load address 0x10, size 11 -> write strobe for 1 cycle; resp_valid 2 cycles after accept; load returns 0x0123456789ABCDEF with resp_fault = 0.
- Sign extension: store byte 0x80 at 0x21, then load 0x21 size 00 signed -> 0xFFFFFFFFFFFFFF80; the same load unsigned -> 0x0000000000000080. Signed load of 0x7FFF size 01 -> 0x0000000000007FFF.
- Misalignment: load address 0x12 size 10 -> resp_fault = 1 one cycle after accept, resp_rdata = 0, no mem_read or mem_write assertion. Address 0x12 size 01 -> no fault.
- Latency parameters: READ_LATENCY = 3, WRITE_CYCLES = 2 -> mem_read high exactly 3 cycles and mem_write high exactly 2 cycles; responses at +4 and +3 cycles respectively; req_ready low throughout.
- Reset mid-read: assert reset_n low in the 2nd READ cycle (READ_LATENCY = 3) -> all strobes 0 and bus_data high-Z immediately; no resp_valid; after release a new load completes normally.
- Tristate check: throughout a mixed sequence, bus_data is high-Z whenever state != WRITE, and the read and write strobes are never simultaneously high (assertion).
